// File: rtl/prienc_drain.sv
// Sequential priority encoder: latches a request vector and drains its set-bit indices, highest first.
// Optional zero-vector beat enabled by defining PRIENC_ZERO_BEAT_EN.
module prienc_drain #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
);

`ifdef PRIENC_ZERO_BEAT_EN
  localparam bit ZERO_BEAT = 1'b1;
`else
  localparam bit ZERO_BEAT = 1'b0;
`endif

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic             accept, beat, zero_nxt;

  function automatic logic [IDX_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) msb_idx = IDX_W'(i);
  endfunction

  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    one_hot = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  assign beat     = out_valid && out_ready;
  // Closing the final beat frees the block in the same cycle, so vectors stream without a bubble.
  assign in_ready = !rst && ((state == IDLE) || (beat && out_last));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == DRAIN);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pend_nxt  = pend;
    state_nxt = state;
    if (beat) begin
      pend_nxt = pend & ~(WIDTH'(1) << out_idx);
      if (out_last) state_nxt = IDLE;
    end
    if (accept) begin
      pend_nxt  = in_data;
      state_nxt = ((in_data != '0) || ZERO_BEAT) ? DRAIN : IDLE;
    end
    // An empty pend while draining can only be the zero-vector beat.
    zero_nxt = ZERO_BEAT && (state_nxt == DRAIN) && (pend_nxt == '0);
  end

  // Outputs are derived from the next pend so they are registered alongside it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      out_valid <= (state_nxt == DRAIN);
      out_idx   <= msb_idx(pend_nxt);
      out_last  <= (state_nxt == DRAIN) && (one_hot(pend_nxt) || zero_nxt);
      out_zero  <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_prienc_drain.sv
// Scoreboard bench for prienc_drain: one 8-bit and one 16-bit instance.
// Expected beats are pushed when a vector is driven and popped by the output monitors.
module tb_prienc_drain;

`ifdef PRIENC_ZERO_BEAT_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_zero8, busy8;
  logic [7:0]  in_data8;
  logic [2:0]  out_idx8;
  logic        rst16, in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_zero16, busy16;
  logic [15:0] in_data16;
  logic [3:0]  out_idx16;

  prienc_drain #(.WIDTH(8), .IDX_W(3)) u8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8), .out_last(out_last8),
    .out_zero(out_zero8), .busy(busy8));

  prienc_drain #(.WIDTH(16), .IDX_W(4)) u16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_idx(out_idx16), .out_last(out_last16),
    .out_zero(out_zero16), .busy(busy16));

  typedef struct packed {
    logic [5:0] idx;
    logic       last;
    logic       zero;
  } beat_t;

  beat_t q8[$];
  beat_t q16[$];
  beat_t e8, e16;
  int vectors = 0;
  int miscompares = 0;
  int beats16 = 0;

  // Reference model: indices of set bits, highest first; last = lowest set bit.
  task automatic push_vec(input int w, input logic [63:0] v);
    beat_t b;
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) begin
        b.idx  = 6'(i);
        b.last = ((v & ((64'd1 << i) - 64'd1)) == 64'd0);
        b.zero = 1'b0;
        if (w == 8) q8.push_back(b); else q16.push_back(b);
      end
    end
    if (v == 64'd0 && ZB) begin
      b = '{idx: 6'd0, last: 1'b1, zero: 1'b1};
      if (w == 8) q8.push_back(b); else q16.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst8 && out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
      vectors++;
      if (q8.size() == 0) begin
        miscompares++;
        $display("FAIL beat8_unexpected idx=%0d last=%b zero=%b", out_idx8, out_last8, out_zero8);
      end else begin
        e8 = q8.pop_front();
        if ({out_idx8, out_last8, out_zero8} !== {e8.idx[2:0], e8.last, e8.zero}) begin
          miscompares++;
          $display("FAIL beat8 got idx=%0d last=%b zero=%b want idx=%0d last=%b zero=%b",
                   out_idx8, out_last8, out_zero8, e8.idx, e8.last, e8.zero);
        end
      end
    end
    if (!rst16 && out_valid16 === 1'b1 && out_ready16 === 1'b1) begin
      vectors++;
      beats16++;
      if (q16.size() == 0) begin
        miscompares++;
        $display("FAIL beat16_unexpected idx=%0d last=%b zero=%b", out_idx16, out_last16, out_zero16);
      end else begin
        e16 = q16.pop_front();
        if ({out_idx16, out_last16, out_zero16} !== {e16.idx[3:0], e16.last, e16.zero}) begin
          miscompares++;
          $display("FAIL beat16 got idx=%0d last=%b zero=%b want idx=%0d last=%b zero=%b",
                   out_idx16, out_last16, out_zero16, e16.idx, e16.last, e16.zero);
        end
      end
    end
  end

  // Drives one vector and returns just after its acceptance edge.
  task automatic drive8(input logic [7:0] v);
    int n = 0;
    push_vec(8, 64'(v));
    @(posedge clk); #1;
    in_valid8 = 1'b1;
    in_data8  = v;
    @(negedge clk);
    while (in_ready8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready8 !== 1'b1) begin
      miscompares++;
      $display("FAIL accept8 in_ready=%b want 1", in_ready8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_data8  = 8'($urandom);
  endtask

  task automatic drive16(input logic [15:0] v);
    int n = 0;
    push_vec(16, 64'(v));
    @(posedge clk); #1;
    in_valid16 = 1'b1;
    in_data16  = v;
    @(negedge clk);
    while (in_ready16 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready16 !== 1'b1) begin
      miscompares++;
      $display("FAIL accept16 in_ready=%b want 1", in_ready16);
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    in_data16  = 16'($urandom);
  endtask

  task automatic wait_empty(input int w);
    int n = 0;
    while (((w == 8) ? q8.size() : q16.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (((w == 8) ? q8.size() : q16.size()) != 0) begin
      miscompares++;
      $display("FAIL drain%0d_timeout beats_left=%0d want 0", w, (w == 8) ? q8.size() : q16.size());
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    rst16 = 1'b1; in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready8, out_valid8, out_idx8, out_last8, out_zero8, busy8} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset8 got rdy=%b vld=%b idx=%0d last=%b zero=%b busy=%b want all 0",
               in_ready8, out_valid8, out_idx8, out_last8, out_zero8, busy8);
    end
    vectors++;
    if ({in_ready16, out_valid16, out_idx16, out_last16, out_zero16, busy16} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset16 got rdy=%b vld=%b idx=%0d want all 0", in_ready16, out_valid16, out_idx16);
    end
    @(posedge clk); #1;
    rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready8, in_ready16} !== 2'b11) begin
      miscompares++;
      $display("FAIL ready_after_reset got %b%b want 11", in_ready8, in_ready16);
    end
  endtask

  task automatic test_multi_bit();
    out_ready8 = 1'b1;
    drive8(8'b1010_0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid8 !== 1'b1 || busy8 !== 1'b1 || (k == 2 && in_ready8 !== 1'b1)) begin
        miscompares++;
        $display("FAIL multi_cycle%0d vld=%b busy=%b rdy=%b want 1 1 %s",
                 k, out_valid8, busy8, in_ready8, (k == 2) ? "1" : "x");
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_idle vld=%b busy=%b want 0 0", out_valid8, busy8);
    end
  endtask

  task automatic test_single();
    drive8(8'b0000_0001);
    @(negedge clk);
    vectors++;
    if (out_valid8 !== 1'b1 || out_last8 !== 1'b1) begin
      miscompares++;
      $display("FAIL single_beat vld=%b last=%b want 1 1", out_valid8, out_last8);
    end
    @(negedge clk);
    vectors++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle vld=%b busy=%b want 0 0", out_valid8, busy8);
    end
  endtask

  task automatic test_backpressure();
    out_ready8 = 1'b0;
    drive8(8'b1100_0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid8, out_idx8, out_last8, out_zero8} !== {1'b1, 3'd7, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall%0d vld=%b idx=%0d last=%b want 1 7 0", k, out_valid8, out_idx8, out_last8);
      end
      @(posedge clk); #1;
      in_data8 = (k == 1) ? 8'hxx : 8'($urandom);
    end
    out_ready8 = 1'b1;
    wait_empty(8);
    @(negedge clk);
    vectors++;
    if (out_valid8 !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle vld=%b want 0", out_valid8);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    push_vec(8, 64'h10);
    push_vec(8, 64'h06);
    in_valid8 = 1'b1; in_data8 = 8'b0001_0000; out_ready8 = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready8 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_ready rdy=%b want 1", in_ready8);
    end
    @(posedge clk); #1;
    in_data8 = 8'b0000_0110;
    @(negedge clk);
    vectors++;
    if ({out_valid8, out_last8, in_ready8} !== 3'b111) begin
      miscompares++;
      $display("FAIL b2b_handover vld=%b last=%b rdy=%b want 1 1 1", out_valid8, out_last8, in_ready8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid8 !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_bubble%0d vld=%b want 1", k, out_valid8);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid8 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle vld=%b want 0", out_valid8);
    end
  endtask

  task automatic test_zero();
    drive8(8'h00);
    @(negedge clk);
    vectors++;
    if (ZB) begin
      if ({out_valid8, out_idx8, out_last8, out_zero8} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL zero_beat vld=%b idx=%0d last=%b zero=%b want 1 0 1 1",
                 out_valid8, out_idx8, out_last8, out_zero8);
      end
    end else begin
      if ({out_valid8, in_ready8, busy8, out_zero8} !== 4'b0100) begin
        miscompares++;
        $display("FAIL zero_silent vld=%b rdy=%b busy=%b zero=%b want 0 1 0 0",
                 out_valid8, in_ready8, busy8, out_zero8);
      end
    end
    drive8(8'b0000_0010);
    wait_empty(8);
  endtask

  task automatic test_reset_mid_drain();
    out_ready16 = 1'b1;
    beats16 = 0;
    drive16(16'h8001);
    @(negedge clk);
    vectors++;
    if (out_valid16 !== 1'b1 || out_idx16 !== 4'd15) begin
      miscompares++;
      $display("FAIL w16_first vld=%b idx=%0d want 1 15", out_valid16, out_idx16);
    end
    @(posedge clk); #1;
    rst16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({in_ready16, out_valid16, out_idx16, out_last16, out_zero16, busy16} !== 9'b0) begin
      miscompares++;
      $display("FAIL w16_reset rdy=%b vld=%b idx=%0d last=%b busy=%b want all 0",
               in_ready16, out_valid16, out_idx16, out_last16, busy16);
    end
    vectors++;
    if (beats16 != 1) begin
      miscompares++;
      $display("FAIL w16_beats_before_reset got %0d want 1", beats16);
    end
    q16.delete();
    @(posedge clk); #1;
    rst16 = 1'b0; out_ready16 = 1'b1;
    drive16(16'h0400);
    @(negedge clk);
    vectors++;
    if ({out_valid16, out_idx16, out_last16} !== {1'b1, 4'd10, 1'b1}) begin
      miscompares++;
      $display("FAIL w16_after_reset vld=%b idx=%0d last=%b want 1 10 1", out_valid16, out_idx16, out_last16);
    end
    wait_empty(16);
  endtask

  initial begin
    test_reset();
    test_multi_bit();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_zero();
    test_reset_mid_drain();
    repeat (3) @(negedge clk);
    vectors++;
    if (q8.size() != 0 || q16.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_beats q8=%0d q16=%0d want 0 0", q8.size(), q16.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
